// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//  Shared constants for the PWM time base: counting-mode encodings and the
//  default parameter values used by pwm_timebase and pwm_prescaler.
// ---------------------------------------------------------------------------
package pwm_pkg;

   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_CENTER = 2'b10;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_PRESC_W = 8;
   localparam int DEF_MAX_EXP = 15;

endpackage

// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler
//  Power-of-two prescaler. Counts enabled clocks and raises tick once every
//  2^min(prescale, MAX_EXP) clocks.
// Ports
//  clk       in   system clock, rising edge
//  rst_n     in   asynchronous active-low reset
//  en        in   count enable; when low the prescaler is cleared
//  clr       in   synchronous clear (no tick while asserted)
//  prescale  in   exponent e
//  tick      out  combinational step strobe, valid in the current cycle
// ---------------------------------------------------------------------------
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int PRESC_W = DEF_PRESC_W,
   parameter int MAX_EXP = DEF_MAX_EXP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] prescale,
   output logic               tick
);

   logic [MAX_EXP-1:0] pc;
   logic [MAX_EXP-1:0] limit;
   int                 e_eff;

   // Terminal count is 2^e-1. Using ">=" rather than "==" means a lowered
   // exponent fires immediately instead of waiting for pc to wrap.
   always_comb begin
      e_eff = MAX_EXP;
      if (int'(prescale) < MAX_EXP) e_eff = int'(prescale);
      limit = MAX_EXP'((64'd1 << e_eff) - 64'd1);
      tick  = en && !clr && (pc >= limit);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 pc <= '0;
      else if (clr || !en || tick) pc <= '0;
      else                         pc <= pc + 1'b1;
   end

endmodule

// File: rtl/pwm_timebase.sv
// ---------------------------------------------------------------------------
// pwm_timebase
//  PWM time base: prescaled period counter with UP, DOWN and CENTER modes,
//  a shadowed period register reloaded at cycle boundaries, and registered
//  one-clock ovf/unf event pulses aligned with the wrapped count.
// Ports
//  clk          in   system clock, rising edge
//  rst_n        in   asynchronous active-low reset
//  en           in   count enable
//  count_reset  in   synchronous counter clear (highest priority)
//  mode         in   00 UP, 01 DOWN, 10 CENTER, 11 treated as UP
//  period       in   terminal value P (counter range 0..P)
//  prescale     in   prescale exponent
//  count_val    out  current count
//  dir          out  1 = counting up, 0 = counting down
//  ovf          out  one-clock top-of-cycle pulse
//  unf          out  one-clock bottom-of-cycle pulse
// ---------------------------------------------------------------------------
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = DEF_PRESC_W,
   parameter int MAX_EXP = DEF_MAX_EXP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               count_reset,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   period,
   input  logic [PRESC_W-1:0] prescale,
   output logic [WIDTH-1:0]   count_val,
   output logic               dir,
   output logic               ovf,
   output logic               unf
);

   logic             tick;
   logic [WIDTH-1:0] ps;        // shadow period in use for the current cycle
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] ps_n;
   logic             dir_n;
   logic             ovf_n;
   logic             unf_n;

   pwm_prescaler #(
      .PRESC_W (PRESC_W),
      .MAX_EXP (MAX_EXP)
   ) u_presc (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (count_reset),
      .prescale (prescale),
      .tick     (tick)
   );

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      count_n = count_val;
      dir_n   = dir;
      ovf_n   = 1'b0;
      unf_n   = 1'b0;
      ps_n    = ps;

      if (count_reset) begin
         count_n = '0;
         dir_n   = (mode != MODE_DOWN);
         ps_n    = period;
      end else if (!en) begin
         ps_n = period;
      end else if (tick) begin
         case (mode)
            MODE_DOWN: begin
               dir_n = 1'b0;
               if (count_val == '0) begin
                  count_n = ps;
                  unf_n   = 1'b1;
               end else if (count_val > ps) begin
                  // Period shrank below the count: clamp to the new top.
                  count_n = ps;
               end else begin
                  count_n = count_val - 1'b1;
               end
            end
            MODE_CENTER: begin
               if (ps == '0) begin
                  // Degenerate range: Ps-1 would wrap, so pin at zero.
                  count_n = '0;
                  ovf_n   = 1'b1;
               end else if (dir) begin
                  if (count_val >= ps) begin
                     count_n = ps - 1'b1;
                     dir_n   = 1'b0;
                     ovf_n   = 1'b1;
                  end else begin
                     count_n = count_val + 1'b1;
                  end
               end else begin
                  if (count_val == '0) begin
                     count_n = {{(WIDTH-1){1'b0}}, 1'b1};
                     dir_n   = 1'b1;
                     unf_n   = 1'b1;
                  end else begin
                     count_n = count_val - 1'b1;
                  end
               end
            end
            default: begin  // UP and the reserved encoding
               dir_n = 1'b1;
               if (count_val >= ps) begin
                  count_n = '0;
                  ovf_n   = 1'b1;
               end else begin
                  count_n = count_val + 1'b1;
               end
            end
         endcase
         // Period writes only land at a cycle boundary.
         if (ovf_n || unf_n) ps_n = period;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_val <= '0;
         dir       <= 1'b1;
         ovf       <= 1'b0;
         unf       <= 1'b0;
         ps        <= '0;
      end else begin
         count_val <= count_n;
         dir       <= dir_n;
         ovf       <= ovf_n;
         unf       <= unf_n;
         ps        <= ps_n;
      end
   end

endmodule

// File: tb/tb_pwm_timebase.sv
// ---------------------------------------------------------------------------
// tb_pwm_timebase
//  Directed bench for pwm_timebase. The stimulus process drives one clock of
//  inputs at a time and pushes the hand-computed response into a queue; the
//  monitor pops one entry after each rising edge and compares.
// ---------------------------------------------------------------------------
module tb_pwm_timebase;
   import pwm_pkg::*;

   typedef struct {
      logic [15:0] cnt;
      logic        d;
      logic        o;
      logic        u;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        count_reset;
   logic [1:0]  mode;
   logic [15:0] period;
   logic [7:0]  prescale;
   logic [15:0] count_val;
   logic        dir;
   logic        ovf;
   logic        unf;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   pwm_timebase dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .count_reset (count_reset),
      .mode        (mode),
      .period      (period),
      .prescale    (prescale),
      .count_val   (count_val),
      .dir         (dir),
      .ovf         (ovf),
      .unf         (unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got cnt=%0d dir=%b ovf=%b unf=%b, expected cnt=%0d dir=%b ovf=%b unf=%b",
                    name, act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
   endtask

   // Drive one clock of stimulus (called at a falling edge) and queue the
   // state expected right after the following rising edge.
   task automatic step(input logic e, input logic cr, input logic [1:0] m,
                       input logic [15:0] p, input logic [7:0] pr,
                       input logic [15:0] c, input logic d, input logic o,
                       input logic u, input string nm);
      exp_t x;
      en          = e;
      count_reset = cr;
      mode        = m;
      period      = p;
      prescale    = pr;
      x.cnt = c; x.d = d; x.o = o; x.u = u; x.name = nm;
      sb.push_back(x);
      @(negedge clk);
   endtask

   // Monitor: the DUT presents a new state every clock.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check(x.name, {count_val, dir, ovf, unf}, {x.cnt, x.d, x.o, x.u});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; count_reset = 1'b0;
      mode = MODE_UP; period = 16'd0; prescale = 8'd0;
      #20 rst_n = 1'b1;
      #1 check("reset", {count_val, dir, ovf, unf}, {16'd0, 1'b1, 1'b0, 1'b0});
      @(negedge clk);

      // UP, P=8, e=0: 1..8 then wrap to 0 with ovf.
      step(0, 1, MODE_UP, 8, 0, 0, 1, 0, 0, "up_clear");
      for (int k = 1; k <= 8; k++) step(1, 0, MODE_UP, 8, 0, 16'(k), 1, 0, 0, "up_count");
      step(1, 0, MODE_UP, 8, 0, 0, 1, 1, 0, "up_wrap");
      step(1, 0, MODE_UP, 8, 0, 1, 1, 0, 0, "up_after_wrap");

      // Prescale e=2: one step every 4 clocks, then e->0 steps at once.
      step(1, 0, MODE_UP, 8, 2, 1, 1, 0, 0, "presc_wait");
      step(1, 0, MODE_UP, 8, 2, 1, 1, 0, 0, "presc_wait");
      step(1, 0, MODE_UP, 8, 2, 1, 1, 0, 0, "presc_wait");
      step(1, 0, MODE_UP, 8, 2, 2, 1, 0, 0, "presc_tick");
      step(1, 0, MODE_UP, 8, 2, 2, 1, 0, 0, "presc_wait");
      step(1, 0, MODE_UP, 8, 2, 2, 1, 0, 0, "presc_wait");
      step(1, 0, MODE_UP, 8, 2, 2, 1, 0, 0, "presc_wait");
      step(1, 0, MODE_UP, 8, 2, 3, 1, 0, 0, "presc_tick");
      step(1, 0, MODE_UP, 8, 2, 3, 1, 0, 0, "presc_mid");
      step(1, 0, MODE_UP, 8, 2, 3, 1, 0, 0, "presc_mid");
      step(1, 0, MODE_UP, 8, 0, 4, 1, 0, 0, "presc_lower_e");
      step(0, 0, MODE_UP, 8, 0, 4, 1, 0, 0, "en_low_hold");

      // DOWN, P=8 from 0: 8 with unf, 7..0, 8 with unf.
      step(0, 1, MODE_DOWN, 8, 0, 0, 0, 0, 0, "down_clear");
      step(1, 0, MODE_DOWN, 8, 0, 8, 0, 0, 1, "down_reload");
      for (int k = 7; k >= 0; k--) step(1, 0, MODE_DOWN, 8, 0, 16'(k), 0, 0, 0, "down_count");
      step(1, 0, MODE_DOWN, 8, 0, 8, 0, 0, 1, "down_reload2");

      // CENTER, P=3: 1,2,3,2(ovf),1,0,1(unf),2,3,2(ovf).
      step(0, 1, MODE_CENTER, 3, 0, 0, 1, 0, 0, "ctr_clear");
      step(1, 0, MODE_CENTER, 3, 0, 1, 1, 0, 0, "ctr_up");
      step(1, 0, MODE_CENTER, 3, 0, 2, 1, 0, 0, "ctr_up");
      step(1, 0, MODE_CENTER, 3, 0, 3, 1, 0, 0, "ctr_top");
      step(1, 0, MODE_CENTER, 3, 0, 2, 0, 1, 0, "ctr_turn_down");
      step(1, 0, MODE_CENTER, 3, 0, 1, 0, 0, 0, "ctr_down");
      step(1, 0, MODE_CENTER, 3, 0, 0, 0, 0, 0, "ctr_bottom");
      step(1, 0, MODE_CENTER, 3, 0, 1, 1, 0, 1, "ctr_turn_up");
      step(1, 0, MODE_CENTER, 3, 0, 2, 1, 0, 0, "ctr_up2");
      step(1, 0, MODE_CENTER, 3, 0, 3, 1, 0, 0, "ctr_top2");
      step(1, 0, MODE_CENTER, 3, 0, 2, 0, 1, 0, "ctr_turn_down2");

      // CENTER with P=0 stays at 0 and pulses ovf every tick.
      step(0, 1, MODE_CENTER, 0, 0, 0, 1, 0, 0, "ctr0_clear");
      step(1, 0, MODE_CENTER, 0, 0, 0, 1, 1, 0, "ctr0_tick");
      step(1, 0, MODE_CENTER, 0, 0, 0, 1, 1, 0, "ctr0_tick");

      // Reserved mode behaves as UP.
      step(0, 1, 2'b11, 2, 0, 0, 1, 0, 0, "rsvd_clear");
      step(1, 0, 2'b11, 2, 0, 1, 1, 0, 0, "rsvd_up");
      step(1, 0, 2'b11, 2, 0, 2, 1, 0, 0, "rsvd_up");
      step(1, 0, 2'b11, 2, 0, 0, 1, 1, 0, "rsvd_wrap");

      // Shadow period: P 8->4 mid-cycle wraps at 8 once, then at 4.
      step(0, 1, MODE_UP, 8, 0, 0, 1, 0, 0, "shd_clear");
      step(1, 0, MODE_UP, 8, 0, 1, 1, 0, 0, "shd_up");
      step(1, 0, MODE_UP, 8, 0, 2, 1, 0, 0, "shd_up");
      for (int k = 3; k <= 8; k++) step(1, 0, MODE_UP, 4, 0, 16'(k), 1, 0, 0, "shd_old_period");
      step(1, 0, MODE_UP, 4, 0, 0, 1, 1, 0, "shd_wrap_old");
      for (int k = 1; k <= 4; k++) step(1, 0, MODE_UP, 4, 0, 16'(k), 1, 0, 0, "shd_new_period");
      step(1, 0, MODE_UP, 4, 0, 0, 1, 1, 0, "shd_wrap_new");

      // count_reset mid-count: immediate 0, no pulse.
      step(1, 0, MODE_UP, 4, 0, 1, 1, 0, 0, "cr_up");
      step(1, 0, MODE_UP, 4, 0, 2, 1, 0, 0, "cr_up");
      step(1, 1, MODE_UP, 4, 0, 0, 1, 0, 0, "cr_mid");
      step(1, 0, MODE_UP, 4, 0, 1, 1, 0, 0, "cr_resume");

      // Async reset mid-count: outputs clear without a clock edge.
      step(1, 0, MODE_UP, 4, 0, 2, 1, 0, 0, "arst_up");
      #2 rst_n = 1'b0;
      #1 check("arst_mid", {count_val, dir, ovf, unf}, {16'd0, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      // Shadow period was cleared to 0, so the first UP tick wraps at once.
      step(1, 0, MODE_UP, 5, 0, 0, 1, 1, 0, "arst_shadow_zero");
      step(1, 0, MODE_UP, 5, 0, 1, 1, 0, 0, "arst_shadow_loaded");

      en = 1'b0;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
